// File: rtl/alu_pkg.sv
// alu_pkg: shared state, width and requester-ID constants for the ALU multiplier sharing logic
package alu_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam int W_OP = 6;
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_DBG = 1'b1;
endpackage

// File: rtl/mul6s.sv
// mul6s: 6-bit sign-magnitude multiplier datapath with XOR-of-upper-bits overflow flag
module mul6s
  import alu_pkg::*;
(
  input  logic [W_OP-1:0] a,
  input  logic [W_OP-1:0] b,
  output logic [W_OP-1:0] m,
  output logic            of
);
  logic [W_OP-1:0] ma, mb;
  logic [9:0] p;
  always_comb begin
    ma = a[W_OP-1] ? -a : a;
    mb = b[W_OP-1] ? -b : b;
    p  = 10'(ma) * 10'(mb);
    m  = (a[W_OP-1] ^ b[W_OP-1]) ? -p[5:0] : p[5:0];
    of = ^p[9:6];
  end
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant, round-robin on ptr or fixed priority to requester 0
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic v0,
  input  logic v1,
  input  logic ptr,
  output logic g0,
  output logic g1
);
  always_comb begin
    g0 = v0 & ((FIXED_PRIO != 0) | ~v1 | ~ptr);
    g1 = v1 & ~g0;
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: arbitrates two requesters onto one shared multiplier and returns a registered response
module mul_share_arbiter
  import alu_pkg::*;
#(
  parameter int FIXED_PRIO  = 0,
  parameter int CALC_CYCLES = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ0_VALID,
  input  logic [W_OP-1:0] REQ0_A,
  input  logic [W_OP-1:0] REQ0_B,
  output logic            REQ0_READY,
  input  logic            REQ1_VALID,
  input  logic [W_OP-1:0] REQ1_A,
  input  logic [W_OP-1:0] REQ1_B,
  output logic            REQ1_READY,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic            RSP_ID,
  output logic [W_OP-1:0] RSP_M,
  output logic            RSP_OF
);
  logic [1:0] state_q, state_d, cnt_q, cnt_d;
  logic ptr_q, ptr_d, id_q, id_d;
  logic [W_OP-1:0] a_q, a_d, b_q, b_d, rsp_m_q, rsp_m_d;
  logic rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_of_q, rsp_of_d;
  logic g0, g1, mul_of, idle;
  logic [W_OP-1:0] mul_m;
  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (.v0(REQ0_VALID), .v1(REQ1_VALID), .ptr(ptr_q), .g0(g0), .g1(g1));
  mul6s u_mul (.a(a_q), .b(b_q), .m(mul_m), .of(mul_of));
  assign idle = ~RST & (state_q == ST_IDLE);
  assign REQ0_READY = idle & g0;
  assign REQ1_READY = idle & g1;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID = rsp_id_q;
  assign RSP_M = rsp_m_q;
  assign RSP_OF = rsp_of_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_m_d = rsp_m_q;
    rsp_of_d = rsp_of_q;
    if (state_q == ST_IDLE && (g0 | g1)) begin
      a_d = g1 ? REQ1_A : REQ0_A;
      b_d = g1 ? REQ1_B : REQ0_B;
      id_d = g1 ? REQ_DBG : REQ_ALU;
      cnt_d = 2'(CALC_CYCLES - 1);
      state_d = ST_CALC;
    end else if (state_q == ST_CALC) begin
      cnt_d = (cnt_q != 2'd0) ? cnt_q - 2'd1 : cnt_q;
      if (cnt_q == 2'd0) begin
        rsp_m_d = mul_m;
        rsp_of_d = mul_of;
        rsp_id_d = id_q;
        rsp_valid_d = 1'b1;
        state_d = ST_HOLD;
      end
    end else if (state_q == ST_HOLD && RSP_READY) begin
      rsp_valid_d = 1'b0;
      ptr_d = (FIXED_PRIO != 0) ? ptr_q : ~rsp_id_q;
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      ptr_q <= 1'b0;
      id_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_m_q <= '0;
      rsp_of_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_m_q <= rsp_m_d;
      rsp_of_q <= rsp_of_d;
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed checks of arbitration, latency, arithmetic, backpressure and reset
module tb_mul_share_arbiter;
  logic clk = 0, rst = 1, rst4 = 1, v0 = 0, v1 = 0, rsp_ready = 0;
  logic [5:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic r0, r1, rv, rid, rof, r0_4, r1_4, rv4, rid4, rof4;
  logic [5:0] rm, rm4;
  int checks = 0, errors = 0;
  logic [5:0] ov_a [5] = '{6'd12, 6'd24, 6'b100000, 6'b111111, 6'd7};
  logic [5:0] ov_b [5] = '{6'd12, 6'd24, 6'd1, 6'b111111, 6'b110111};
  logic [5:0] ov_m [5] = '{6'b010000, 6'b000000, 6'b100000, 6'b000001, 6'b000001};
  logic ov_of [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  always #5 clk = ~clk;
  mul_share_arbiter #(.FIXED_PRIO(0), .CALC_CYCLES(1)) u_dut (
    .CLK(clk), .RST(rst), .REQ0_VALID(v0), .REQ0_A(a0), .REQ0_B(b0), .REQ0_READY(r0),
    .REQ1_VALID(v1), .REQ1_A(a1), .REQ1_B(b1), .REQ1_READY(r1),
    .RSP_VALID(rv), .RSP_READY(rsp_ready), .RSP_ID(rid), .RSP_M(rm), .RSP_OF(rof));
  mul_share_arbiter #(.FIXED_PRIO(0), .CALC_CYCLES(4)) u_dut4 (
    .CLK(clk), .RST(rst4), .REQ0_VALID(v0), .REQ0_A(a0), .REQ0_B(b0), .REQ0_READY(r0_4),
    .REQ1_VALID(v1), .REQ1_A(a1), .REQ1_B(b1), .REQ1_READY(r1_4),
    .RSP_VALID(rv4), .RSP_READY(rsp_ready), .RSP_ID(rid4), .RSP_M(rm4), .RSP_OF(rof4));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic id, input logic [5:0] a, input logic [5:0] b,
                        output logic [5:0] m, output logic of, output logic rsp_id);
    logic got;
    got = 0;
    if (id) begin v1 = 1; a1 = a; b1 = b; end
    else begin v0 = 1; a0 = a; b0 = b; end
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      got = id ? r1 : r0;
      tick();
    end
    v0 = 0;
    v1 = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL run_op accept timeout: ready=0 required=1"); end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (rv) got = 1;
      else tick();
    end
    checks++;
    if (!got) begin errors++; $display("FAIL run_op response timeout: rsp_valid=0 required=1"); end
    m = rm;
    of = rof;
    rsp_id = rid;
    rsp_ready = 1;
    tick();
  endtask
  task automatic test_reset;
    rst = 1; v0 = 1; a0 = 3; b0 = 5;
    tick();
    checks++;
    if (r0 !== 1'b0) begin errors++; $display("FAIL reset_ready: ready0=%b required=0", r0); end
    v0 = 0;
    tick();
    rst = 0;
    repeat (5) tick();
    checks++;
    if ({rv, r0, r1, rid, rof, rm} !== 11'b0)
      begin errors++; $display("FAIL reset_outputs: v=%b r0=%b r1=%b id=%b of=%b m=%b required all 0", rv, r0, r1, rid, rof, rm); end
  endtask
  task automatic test_single;
    rsp_ready = 1; v0 = 1; a0 = 6'd3; b0 = 6'd5;
    #1;
    checks++;
    if ({r0, r1} !== 2'b10) begin errors++; $display("FAIL single_grant: r0r1=%b required=10", {r0, r1}); end
    tick();
    v0 = 0;
    checks++;
    if ({r0, rv} !== 2'b00) begin errors++; $display("FAIL single_calc: r0=%b v=%b required 0 0", r0, rv); end
    tick();
    checks++;
    if ({rv, rid, rof, rm} !== {3'b100, 6'b001111})
      begin errors++; $display("FAIL single_rsp: v=%b id=%b of=%b m=%b required 1 0 0 001111", rv, rid, rof, rm); end
    tick();
    checks++;
    if (rv !== 1'b0) begin errors++; $display("FAIL single_handshake: v=%b required=0", rv); end
  endtask
  task automatic test_dual;
    logic e;
    rst = 1;
    tick();
    rst = 0; rsp_ready = 1;
    a0 = 6'b111101; b0 = 6'd5; a1 = 6'd8; b1 = 6'd8; v0 = 1; v1 = 1;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 1);
      #1;
      checks++;
      if ({r0, r1} !== {~e, e}) begin errors++; $display("FAIL dual_grant%0d: r0r1=%b required=%b", k, {r0, r1}, {~e, e}); end
      tick();
      tick();
      checks++;
      if ({rv, rid, rof, rm} !== {1'b1, e, e, (e ? 6'b000000 : 6'b110001)})
        begin errors++; $display("FAIL dual_rsp%0d: v=%b id=%b of=%b m=%b required 1 %b %b %b", k, rv, rid, rof, rm, e, e, (e ? 6'b000000 : 6'b110001)); end
      tick();
    end
    v0 = 0; v1 = 0;
  endtask
  task automatic test_overflow;
    logic [5:0] m;
    logic of, id;
    rst = 1;
    tick();
    rst = 0; rsp_ready = 1;
    for (int k = 0; k < 5; k++) begin
      run_op(1'b1, ov_a[k], ov_b[k], m, of, id);
      checks++;
      if ({id, of, m} !== {1'b1, ov_of[k], ov_m[k]})
        begin errors++; $display("FAIL arith%0d a=%b b=%b: id=%b of=%b m=%b required 1 %b %b", k, ov_a[k], ov_b[k], id, of, m, ov_of[k], ov_m[k]); end
    end
  endtask
  task automatic test_backpressure;
    rst = 1;
    tick();
    rst = 0; rsp_ready = 0; v0 = 1; a0 = 6'd3; b0 = 6'd5;
    #1;
    checks++;
    if (r0 !== 1'b1) begin errors++; $display("FAIL bp_grant: r0=%b required=1", r0); end
    tick();
    a0 = 6'd2; b0 = 6'd2;
    tick();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({rv, rid, rof, rm, r0} !== {3'b100, 6'b001111, 1'b0})
        begin errors++; $display("FAIL bp_hold%0d: v=%b id=%b of=%b m=%b r0=%b required 1 0 0 001111 0", k, rv, rid, rof, rm, r0); end
      tick();
    end
    rsp_ready = 1;
    tick();
    checks++;
    if ({rv, r0} !== 2'b01) begin errors++; $display("FAIL bp_release: v=%b r0=%b required 0 1", rv, r0); end
    tick();
    v0 = 0;
    tick();
    checks++;
    if ({rv, rm} !== {1'b1, 6'd4}) begin errors++; $display("FAIL bp_next: v=%b m=%b required 1 000100", rv, rm); end
    tick();
  endtask
  task automatic test_reset_calc;
    logic got;
    rst = 1; rst4 = 0; rsp_ready = 1; v1 = 0; v0 = 1; a0 = 6'd3; b0 = 6'd5;
    #1;
    checks++;
    if (r0_4 !== 1'b1) begin errors++; $display("FAIL rc_grant0: r0=%b required=1", r0_4); end
    tick();
    v0 = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (rv4) got = 1;
      else tick();
    end
    checks++;
    if (!got || rm4 !== 6'b001111) begin errors++; $display("FAIL rc_first: v=%b m=%b required 1 001111", rv4, rm4); end
    tick();
    v0 = 1; v1 = 1; a1 = 6'd8; b1 = 6'd8;
    #1;
    checks++;
    if ({r0_4, r1_4} !== 2'b01) begin errors++; $display("FAIL rc_ptr1: r0r1=%b required=01", {r0_4, r1_4}); end
    tick();
    v1 = 0;
    tick();
    checks++;
    if (rv4 !== 1'b0) begin errors++; $display("FAIL rc_calc: v=%b required=0", rv4); end
    rst4 = 1; v1 = 1;
    tick();
    rst4 = 0;
    #1;
    checks++;
    if ({rv4, r0_4, r1_4} !== 3'b010) begin errors++; $display("FAIL rc_after_reset: v=%b r0r1=%b required 0 10", rv4, {r0_4, r1_4}); end
    tick();
    v0 = 0; v1 = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (rv4) got = 1;
      else tick();
    end
    checks++;
    if (!got || {rid4, rof4, rm4} !== {2'b00, 6'b001111})
      begin errors++; $display("FAIL rc_resume: v=%b id=%b of=%b m=%b required 1 0 0 001111", rv4, rid4, rof4, rm4); end
    tick();
    rst4 = 1;
  endtask
  initial begin
    test_reset();
    test_single();
    test_dual();
    test_overflow();
    test_backpressure();
    test_reset_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
